// File: rtl/q2_panel_pkg.sv
// ---------------------------------------------------------------------------
// q2_panel_pkg : state encoding and button indices for the q2 front panel.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package q2_panel_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_DEP   = 0;
  localparam int BTN_INCP  = 1;
  localparam int BTN_START = 2;
  localparam int BTN_STOP  = 3;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_DEP      = 3'd1;
  localparam logic [2:0] ENC_GAP      = 3'd2;
  localparam logic [2:0] ENC_INCP     = 3'd3;
  localparam logic [2:0] ENC_START    = 3'd4;
  localparam logic [2:0] ENC_STOP     = 3'd5;
  localparam logic [2:0] ENC_WAIT_REL = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_DEP      = ENC_DEP,
    ST_GAP      = ENC_GAP,
    ST_INCP     = ENC_INCP,
    ST_START    = ENC_START,
    ST_STOP     = ENC_STOP,
    ST_WAIT_REL = ENC_WAIT_REL
  } state_t;

endpackage

`default_nettype wire

// File: rtl/q2_debounce.sv
// ---------------------------------------------------------------------------
// q2_debounce : 2-flop synchronizer, stability counter and press detector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module q2_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          sync_d;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      sync_d  <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      meta    <= btn;
      sync    <= meta;
      sync_d  <= sync;
      level_d <= level;
      // Counter saturates at LAST; the level keeps tracking a stable input.
      if (sync != sync_d) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

`default_nettype wire

// File: rtl/q2_panel.sv
// ---------------------------------------------------------------------------
// q2_panel : front-panel sequencer feeding clean switch pulses to the q2 core.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module q2_panel
  import q2_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_dep,
  input  logic        btn_incp,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic [11:0] raw_sw,
  input  logic        auto_adv,
  input  logic        run,
  output logic [11:0] sw,
  output logic        dep_sw,
  output logic        incp_sw,
  output logic        start_sw,
  output logic        stop_sw,
  output logic        busy
);

  localparam int            CNT_MAX    = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int            CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [11:0]        sw_meta;
  logic [11:0]        sw_sync;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic               adv;

  assign btn_raw[BTN_DEP]   = btn_dep;
  assign btn_raw[BTN_INCP]  = btn_incp;
  assign btn_raw[BTN_START] = btn_start;
  assign btn_raw[BTN_STOP]  = btn_stop;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    q2_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  // Data switches are held steady outside IDLE so the core latches stable data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw      <= '0;
    end else begin
      sw_meta <= raw_sw;
      sw_sync <= sw_meta;
      if (state == ST_IDLE) begin
        sw <= sw_sync;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      adv      <= 1'b0;
      dep_sw   <= 1'b0;
      incp_sw  <= 1'b0;
      start_sw <= 1'b0;
      stop_sw  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press[BTN_STOP]) begin
            state   <= ST_STOP;
            stop_sw <= 1'b1;
            cnt     <= PULSE_LOAD;
            busy    <= 1'b1;
          end else if (press[BTN_START] && !run) begin
            state    <= ST_START;
            start_sw <= 1'b1;
            cnt      <= PULSE_LOAD;
            busy     <= 1'b1;
          end else if (press[BTN_DEP] && !run) begin
            state  <= ST_DEP;
            dep_sw <= 1'b1;
            adv    <= auto_adv;
            cnt    <= PULSE_LOAD;
            busy   <= 1'b1;
          end else if (press[BTN_INCP] && !run) begin
            state   <= ST_INCP;
            incp_sw <= 1'b1;
            cnt     <= PULSE_LOAD;
            busy    <= 1'b1;
          end
        end
        ST_DEP: begin
          if (cnt == '0) begin
            dep_sw <= 1'b0;
            if (adv) begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= ST_WAIT_REL;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state   <= ST_INCP;
            incp_sw <= 1'b1;
            cnt     <= PULSE_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_INCP, ST_START, ST_STOP: begin
          if (cnt == '0) begin
            state    <= ST_WAIT_REL;
            incp_sw  <= 1'b0;
            start_sw <= 1'b0;
            stop_sw  <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WAIT_REL: begin
          // One action per press: every button must be released first.
          if (level == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          dep_sw   <= 1'b0;
          incp_sw  <= 1'b0;
          start_sw <= 1'b0;
          stop_sw  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_q2_panel.sv
// ---------------------------------------------------------------------------
// tb_q2_panel : directed, table-driven bench for the q2 front-panel sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_q2_panel;

  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'b0;   // {stop, start, incp, dep}
  logic [11:0] raw_sw = 12'h000;
  logic        auto_adv = 1'b0;
  logic        run = 1'b0;
  logic [11:0] sw;
  logic        dep_sw, incp_sw, start_sw, stop_sw, busy;

  q2_panel #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_dep  (btns[0]),
    .btn_incp (btns[1]),
    .btn_start(btns[2]),
    .btn_stop (btns[3]),
    .raw_sw   (raw_sw),
    .auto_adv (auto_adv),
    .run      (run),
    .sw       (sw),
    .dep_sw   (dep_sw),
    .incp_sw  (incp_sw),
    .start_sw (start_sw),
    .stop_sw  (stop_sw),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Observer: pulse starts, pulse widths, exclusivity, busy and sw stability.
  int          rises [4] = '{0, 0, 0, 0};
  int          run_len [4] = '{0, 0, 0, 0};
  int          width_err = 0;
  int          onehot_err = 0;
  int          busy_cnt = 0;
  int          sw_bad = 0;
  logic        sw_watch = 1'b0;
  logic [11:0] sw_exp = 12'h000;
  logic [3:0]  mon_o;

  always @(negedge clk) begin
    mon_o = {stop_sw, start_sw, incp_sw, dep_sw};
    if ($countones(mon_o) > 1) onehot_err++;
    if (busy) busy_cnt++;
    if (sw_watch && sw !== sw_exp) sw_bad++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        run_len[i] = 0;
      end else if (mon_o[i]) begin
        if (run_len[i] == 0) rises[i]++;
        run_len[i]++;
      end else begin
        if (run_len[i] != 0 && run_len[i] != PUL) width_err++;
        run_len[i] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  int base [4];
  task automatic snap();
    for (int i = 0; i < 4; i++) base[i] = rises[i];
  endtask

  // Pulse-count deltas since snap(), one nibble per output {stop,start,incp,dep}.
  function automatic logic [15:0] deltas();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[i*4 +: 4] = 4'(rises[i] - base[i]);
    return d;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (12) @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int idx, input int hold);
    btns[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    btns[idx] = 1'b0;
    wait_idle();
  endtask

  typedef struct packed {
    logic        run;
    logic        adv;
    logic [1:0]  btn;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] dmask, imask;
  int          n;

  initial begin
    tbl[0] = {1'b0, 1'b0, 2'd0, 16'h0001};
    tbl[1] = {1'b0, 1'b1, 2'd0, 16'h0011};
    tbl[2] = {1'b0, 1'b0, 2'd1, 16'h0010};
    tbl[3] = {1'b0, 1'b1, 2'd1, 16'h0010};
    tbl[4] = {1'b0, 1'b0, 2'd2, 16'h0100};
    tbl[5] = {1'b0, 1'b0, 2'd3, 16'h1000};
    tbl[6] = {1'b1, 1'b1, 2'd0, 16'h0000};
    tbl[7] = {1'b1, 1'b0, 2'd1, 16'h0000};
    tbl[8] = {1'b1, 1'b0, 2'd2, 16'h0000};
    tbl[9] = {1'b1, 1'b0, 2'd3, 16'h1000};

    // Reset state: everything low, sw cleared even with switches set.
    raw_sw = 12'hFFF;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {15'b0, sw, dep_sw, incp_sw, start_sw, stop_sw, busy}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("sw_follow_idle", 32'(sw), 32'h0FFF);

    // Bouncing deposit button, then a clean hold.
    raw_sw = 12'hA5C;
    repeat (5) @(negedge clk);
    sw_exp = 12'hA5C;
    sw_watch = 1'b1;
    n = sw_bad;
    snap();
    for (int i = 0; i < 10; i++) begin
      btns[0] = (i % 2 == 0);
      @(negedge clk);
    end
    btns[0] = 1'b1;
    repeat (25) @(negedge clk);
    chk("bounce_pulses", 32'(deltas()), 32'h0001);
    chk("bounce_sw_stable", 32'(sw_bad - n), 32'h0);
    sw_watch = 1'b0;
    btns[0] = 1'b0;
    wait_idle();

    // Deposit-and-advance: 2 sync + debounce gives dep_sw at negedge 8,
    // high 8-9, gap 10-12, incp_sw high 13-14.
    auto_adv = 1'b1;
    btns[0] = 1'b1;
    dmask = '0;
    imask = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      dmask[k] = dep_sw;
      imask[k] = incp_sw;
      if (k == 11) raw_sw = 12'h123;
    end
    chk("adv_dep_shape", dmask, 32'h0000_0300);
    chk("adv_incp_shape", imask, 32'h0000_6000);
    repeat (4) @(negedge clk);
    chk("adv_sw_frozen", 32'(sw), 32'h0A5C);
    btns[0] = 1'b0;
    wait_idle();
    chk("adv_sw_updated", 32'(sw), 32'h0123);

    // Table of single clean presses across run/auto_adv combinations.
    for (int r = 0; r < 10; r++) begin
      run = tbl[r].run;
      auto_adv = tbl[r].adv;
      snap();
      press(int'(tbl[r].btn), 25);
      chk($sformatf("table_row%0d", r), 32'(deltas()), 32'(tbl[r].exp));
    end

    // Interlock: run=1 blocks dep/start/incp without ever leaving IDLE.
    run = 1'b1;
    auto_adv = 1'b0;
    n = busy_cnt;
    snap();
    press(0, 20);
    press(2, 20);
    press(1, 20);
    chk("interlock_busy", 32'(busy_cnt - n), 32'h0);
    chk("interlock_pulses", 32'(deltas()), 32'h0);
    snap();
    press(3, 20);
    chk("interlock_stop", 32'(deltas()), 32'h1000);

    // Simultaneous start+stop: stop wins, held buttons give nothing more.
    run = 1'b0;
    snap();
    btns[2] = 1'b1;
    btns[3] = 1'b1;
    repeat (40) @(negedge clk);
    chk("simul_first", 32'(deltas()), 32'h1000);
    btns = 4'b0;
    wait_idle();
    snap();
    btns[2] = 1'b1;
    btns[3] = 1'b1;
    repeat (25) @(negedge clk);
    btns = 4'b0;
    wait_idle();
    chk("simul_second", 32'(deltas()), 32'h1000);

    // Reset on the first cycle of start_sw with the button kept held.
    btns[2] = 1'b1;
    n = 0;
    while (!start_sw && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_first_latency", 32'(n), 32'd8);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_pulse", {30'b0, start_sw, busy}, 32'h0);
    #1 rst = 1'b0;
    n = 0;
    while (!start_sw && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_held_latency", 32'(n), 32'd8);
    btns[2] = 1'b0;
    wait_idle();

    // Long hold of incp: single pulse, busy until release.
    snap();
    btns[1] = 1'b1;
    repeat (50) @(negedge clk);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_pulses", 32'(deltas()), 32'h0010);
    btns[1] = 1'b0;
    wait_idle();
    chk("hold_released", 32'(busy), 32'h0);

    chk("pulse_widths", 32'(width_err), 32'h0);
    chk("pulse_exclusive", 32'(onehot_err), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
